// File: rtl/can_frame_rx_pkg.sv
// Shared types and constants for the CAN frame receiver.
// Optional destuffing is selected with the CAN_RX_DESTUFF_EN macro.
package can_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ID   = 3'd1,
        DLC  = 3'd2,
        DATA = 3'd3,
        EOF  = 3'd4
    } rx_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_FORM  = 2'b01;
    localparam logic [1:0] ERR_STUFF = 2'b10;

    localparam int DLC_BYTES_MAX = 8;
    localparam int STUFF_RUN     = 5;

endpackage

// File: rtl/can_frame_rx_destuffer.sv
// Bit destuffer: tracks the run of equal bus levels and flags the stuff bit.
// Only instantiated when CAN_RX_DESTUFF_EN is defined.
module can_bit_destuffer
    import can_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic rx_bit,
    input  logic i_start,
    input  logic i_active,
    output logic o_stuff,
    output logic o_err
);

    logic [2:0] r_run;
    logic       r_last;

    assign o_stuff = bit_en && i_active && (r_run == 3'(STUFF_RUN));
    assign o_err   = o_stuff && (rx_bit == r_last);

    // The stuff bit itself starts the next run, as does any level change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run  <= 3'd0;
            r_last <= 1'b1;
        end else if (bit_en) begin
            if (i_start) begin
                r_run  <= 3'd1;
                r_last <= rx_bit;
            end else if (i_active) begin
                if (o_stuff || (rx_bit != r_last)) begin
                    r_run  <= 3'd1;
                    r_last <= rx_bit;
                end else begin
                    r_run  <= r_run + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/can_frame_rx.sv
// CAN frame receiver: deserialises SOF/ID/DLC/data and checks EOF framing.
// Define CAN_RX_DESTUFF_EN to enable bit destuffing from SOF to the last data bit.
module can_frame_rx
    import can_pkg::*;
#(
    parameter int ID_W      = 11,
    parameter int MAX_BYTES = DLC_BYTES_MAX,
    parameter int IFS_BITS  = 3,
    parameter int EOF_BITS  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bit_en,
    input  logic                   rx_bit,
    output logic                   busy,
    output logic                   frame_valid,
    output logic [ID_W-1:0]        rx_id,
    output logic [3:0]             rx_dlc,
    output logic [8*MAX_BYTES-1:0] rx_data,
    output logic                   err,
    output logic [1:0]             err_code
);

    localparam int DATA_W = 8 * MAX_BYTES;
    localparam int CNT_W  = $clog2(DATA_W + ID_W + EOF_BITS + 1);
    localparam int RC_W   = $clog2(IFS_BITS + 1);
    localparam int DIDX_W = $clog2(DATA_W);

    localparam logic [RC_W-1:0]  IFS_CNT  = RC_W'(IFS_BITS);
    localparam logic [CNT_W-1:0] ID_LAST  = CNT_W'(ID_W - 1);
    localparam logic [CNT_W-1:0] DLC_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_BITS - 1);
    localparam logic [CNT_W-1:0] NB_MAX   = CNT_W'(MAX_BYTES);

    rx_state_e          r_state, w_state_nxt;
    logic [RC_W-1:0]    r_rcnt;
    logic [CNT_W-1:0]   r_cnt, r_data_last;
    logic [ID_W-1:0]    r_id_sh, r_rx_id;
    logic [3:0]         r_dlc_sh, r_rx_dlc;
    logic [DATA_W-1:0]  r_data_sh, r_rx_data;
    logic               r_frame_valid, r_err;
    logic [1:0]         r_err_code;

    logic               w_sof, w_done, w_form_err, w_bit;
    logic               w_stuff, w_stuff_err;
    logic [3:0]         w_dlc_new;
    logic [CNT_W-1:0]   w_dlc_ext, w_nbytes;
    logic [DIDX_W-1:0]  w_data_idx;

`ifdef CAN_RX_DESTUFF_EN
    can_bit_destuffer u_destuffer (
        .clk      (clk),
        .rst      (rst),
        .bit_en   (bit_en),
        .rx_bit   (rx_bit),
        .i_start  (w_sof),
        .i_active ((r_state == ID) || (r_state == DLC) || (r_state == DATA)),
        .o_stuff  (w_stuff),
        .o_err    (w_stuff_err)
    );
`else
    assign w_stuff     = 1'b0;
    assign w_stuff_err = 1'b0;
`endif

    assign w_bit      = bit_en && !w_stuff;
    assign w_dlc_new  = {r_dlc_sh[2:0], rx_bit};
    assign w_dlc_ext  = CNT_W'(w_dlc_new);
    assign w_nbytes   = (w_dlc_ext > NB_MAX) ? NB_MAX : w_dlc_ext;
    // Byte k occupies [8k+7:8k] and arrives MSB first: invert the bit-in-byte index.
    assign w_data_idx = {r_cnt[DIDX_W-1:3], ~r_cnt[2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sof       = 1'b0;
        w_done      = 1'b0;
        w_form_err  = 1'b0;
        case (r_state)
            IDLE: if (bit_en && !rx_bit && (r_rcnt == IFS_CNT)) begin
                w_state_nxt = ID;
                w_sof       = 1'b1;
            end
            ID: begin
                if (w_stuff_err)                        w_state_nxt = IDLE;
                else if (w_bit && (r_cnt == ID_LAST))   w_state_nxt = DLC;
            end
            DLC: begin
                if (w_stuff_err)                        w_state_nxt = IDLE;
                else if (w_bit && (r_cnt == DLC_LAST))  w_state_nxt = (w_nbytes == '0) ? EOF : DATA;
            end
            DATA: begin
                if (w_stuff_err)                          w_state_nxt = IDLE;
                else if (w_bit && (r_cnt == r_data_last)) w_state_nxt = EOF;
            end
            EOF: if (bit_en) begin
                if (!rx_bit) begin
                    w_state_nxt = IDLE;
                    w_form_err  = 1'b1;
                end else if (r_cnt == EOF_LAST) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Recessive run only accumulates while idle, so EOF bits never count toward IFS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rcnt <= '0;
        end else if (r_state != IDLE) begin
            r_rcnt <= '0;
        end else if (bit_en) begin
            if (!rx_bit)                r_rcnt <= '0;
            else if (r_rcnt != IFS_CNT) r_rcnt <= r_rcnt + RC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_data_last <= '0;
            r_id_sh     <= '0;
            r_dlc_sh    <= '0;
            r_data_sh   <= '0;
        end else begin
            if (w_state_nxt != r_state)            r_cnt <= '0;
            else if (w_bit && (r_state != IDLE))   r_cnt <= r_cnt + CNT_W'(1);

            if (w_sof) begin
                r_id_sh   <= '0;
                r_dlc_sh  <= '0;
                r_data_sh <= '0;
            end else if (w_bit && !w_stuff_err) begin
                case (r_state)
                    ID:   r_id_sh <= {r_id_sh[ID_W-2:0], rx_bit};
                    DLC: begin
                        r_dlc_sh    <= w_dlc_new;
                        r_data_last <= (w_nbytes << 3) - CNT_W'(1);
                    end
                    DATA: r_data_sh[w_data_idx] <= rx_bit;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_valid <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_rx_id       <= '0;
            r_rx_dlc      <= '0;
            r_rx_data     <= '0;
        end else begin
            r_frame_valid <= w_done;
            r_err         <= w_form_err || w_stuff_err;
            if (w_done) begin
                r_rx_id    <= r_id_sh;
                r_rx_dlc   <= r_dlc_sh;
                r_rx_data  <= r_data_sh;
                r_err_code <= ERR_NONE;
            end else if (w_form_err) begin
                r_err_code <= ERR_FORM;
            end else if (w_stuff_err) begin
                r_err_code <= ERR_STUFF;
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign frame_valid = r_frame_valid;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign rx_id       = r_rx_id;
    assign rx_dlc      = r_rx_dlc;
    assign rx_data     = r_rx_data;

endmodule

// File: tb/tb_can_frame_rx.sv
// Directed bench for can_frame_rx; frame/err events are checked against an expected queue.
// Destuffing vectors run when CAN_RX_DESTUFF_EN is defined, plain framing vectors otherwise.
module tb_can_frame_rx;

    localparam int W = 84;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_en;
    logic        rx_bit;
    logic        busy;
    logic        frame_valid;
    logic [10:0] rx_id;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic        err;
    logic [1:0]  err_code;

    logic [W-1:0] exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [10:0]  last_id;
    logic [3:0]   last_dlc;
    logic [63:0]  last_data;

    always #5 clk = ~clk;

    can_frame_rx dut (
        .clk         (clk),
        .rst         (rst),
        .bit_en      (bit_en),
        .rx_bit      (rx_bit),
        .busy        (busy),
        .frame_valid (frame_valid),
        .rx_id       (rx_id),
        .rx_dlc      (rx_dlc),
        .rx_data     (rx_data),
        .err         (err),
        .err_code    (err_code)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
        exp_q.push_back({1'b0, 1'b1, 1'b0, 2'b00, id, dlc, data});
        last_id   = id;
        last_dlc  = dlc;
        last_data = data;
    endtask

    task automatic exp_err(input logic [1:0] code);
        exp_q.push_back({1'b1, 1'b0, 1'b0, code, last_id, last_dlc, last_data});
    endtask

    // Idle cycles carry random bus levels that must be ignored.
    task automatic send_bit(input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            bit_en = 1'b0;
            rx_bit = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        bit_en = 1'b1;
        rx_bit = b;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        rx_bit = 1'b1;
    endtask

    task automatic send_vec(input logic [63:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic send_head(input logic [10:0] id, input logic [3:0] dlc, input int gap);
        for (int i = 0; i < 3; i++) send_bit(1'b1, gap);
        send_bit(1'b0, gap);
        check("busy_after_sof", busy, 1);
        for (int i = 10; i >= 0; i--) send_bit(id[i], gap);
        for (int i = 3; i >= 0; i--) send_bit(dlc[i], gap);
    endtask

    task automatic send_bytes(input logic [63:0] data, input int nbytes, input int gap);
        for (int k = 0; k < nbytes; k++)
            for (int b = 7; b >= 0; b--) send_bit(data[8*k+b], gap);
    endtask

    task automatic send_eof(input int bad, input int gap);
        for (int i = 0; i < 7; i++) begin
            if (i == bad) begin
                send_bit(1'b0, gap);
                break;
            end
            send_bit(1'b1, gap);
        end
    endtask

    task automatic send_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data,
                              input int nbytes, input int gap, input int bad);
        send_head(id, dlc, gap);
        send_bytes(data, nbytes, gap);
        send_eof(bad, gap);
    endtask

    always @(negedge clk) begin
        if (!rst && (frame_valid || err)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: got fv=%0b err=%0b code=%0b id=0x%0h required no event",
                         frame_valid, err, err_code, rx_id);
            end else begin
                check("event", {err, frame_valid, busy, err_code, rx_id, rx_dlc, rx_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bit_en    = 1'b0;
        rx_bit    = 1'b1;
        last_id   = '0;
        last_dlc  = '0;
        last_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, frame_valid, err, err_code, rx_id, rx_dlc, rx_data}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_outputs", {busy, frame_valid, err, err_code, rx_id, rx_dlc, rx_data}, 0);

`ifndef CAN_RX_DESTUFF_EN
        // Basic frame, strobe every cycle.
        exp_frame(11'h123, 4'd2, 64'h3CA5);
        send_frame(11'h123, 4'd2, 64'h3CA5, 2, 0, -1);
        check("busy_after_frame", busy, 0);

        // Lone recessive then dominant must not start a frame; same frame at 1/4 strobe rate.
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        check("no_sof_after_1_rec", busy, 0);
        exp_frame(11'h123, 4'd2, 64'h3CA5);
        send_frame(11'h123, 4'd2, 64'h3CA5, 2, 3, -1);

        // DLC 0, then DLC 12 clamped to 8 bytes.
        exp_frame(11'h456, 4'd0, 64'h0);
        send_frame(11'h456, 4'd0, 64'h0, 0, 0, -1);
        exp_frame(11'h001, 4'd12, 64'h0807060504030201);
        send_frame(11'h001, 4'd12, 64'h0807060504030201, 8, 1, -1);

        // Dominant in EOF bit 4 is a form error; outputs keep the previous frame.
        exp_err(2'b01);
        send_frame(11'h2AA, 4'd1, 64'h55, 1, 0, 3);
        check("busy_after_form_err", busy, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        check("no_sof_after_2_rec", busy, 0);
        exp_frame(11'h0F0, 4'd3, 64'h00C3B2A1);
        send_frame(11'h0F0, 4'd3, 64'h00C3B2A1, 3, 0, -1);

        // Async reset in the middle of data byte 1.
        send_head(11'h3E1, 4'd2, 0);
        send_bytes(64'h00AA, 1, 0);
        send_vec(64'b101, 3, 0);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {busy, frame_valid, err, err_code, rx_id, rx_dlc, rx_data}, 0);
        last_id   = '0;
        last_dlc  = '0;
        last_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_frame(11'h7FF, 4'd1, 64'h00);
        send_frame(11'h7FF, 4'd1, 64'h00, 1, 0, -1);
`else
        // ID 0x7C0, DLC 0: stuff 0 after five 1s, stuff 1 after five 0s, stuff 1 in DLC.
        exp_frame(11'h7C0, 4'd0, 64'h0);
        send_vec(64'b111_0_11111_0_0000_1_00_000_1_0_1111111, 29, 0);

        // Sixth equal bit where a stuff bit belongs.
        exp_err(2'b10);
        send_vec(64'b111_0_11111_1, 10, 0);
        check("busy_after_stuff_err", busy, 0);

        // ID 0x07F: SOF plus four 0s then stuff 1, later stuff 0 after five 1s.
        exp_frame(11'h07F, 4'd0, 64'h0);
        send_vec(64'b111_0_0000_1_1111_0_111_0000_1111111, 28, 1);
        check("busy_after_destuff_frame", busy, 0);
`endif

        repeat (8) @(posedge clk);
        #1;
        check("exp_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/can_frame_rx.md
Name: can_frame_rx

Overview:
- Bit-level CAN frame receiver: the listening end of the wired-AND arbitration bus driven by the node transmit/arbitration logic.
- Samples the bus line once per bit strobe and deserialises SOF, identifier, DLC and data bytes, all MSB first.
- Checks EOF framing and reports each completed frame as a one-cycle pulse with held output registers.
- Sits between the bus line sampler and the node's message buffer.

Parameters:
- ID_W, 11, identifier width in bits (11 = base frame).
- MAX_BYTES, 8, maximum data bytes stored; sets the width of rx_data.
- IFS_BITS, 3, consecutive recessive bits required before a SOF is accepted.
- EOF_BITS, 7, recessive bits required after the data field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bit_en  in  1  sample strobe, one cycle wide; rx_bit is valid only in strobe cycles; may be asserted every cycle.
- rx_bit  in  1  bus level; 0 = dominant, 1 = recessive.
- busy  out  1  high from the SOF strobe until the end of EOF or an error.
- frame_valid  out  1  one-cycle pulse when a frame completes.
- rx_id  out  ID_W  received identifier.
- rx_dlc  out  4  raw DLC as received.
- rx_data  out  8*MAX_BYTES  data; byte 0 at [7:0], byte k at [8k+7:8k]; bytes not received = 0.
- err  out  1  one-cycle error pulse.
- err_code  out  2  00 none, 01 form (dominant in EOF), 10 stuff; held until the next err or frame_valid.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, recessive counter 0, shadow registers 0. rst mid-frame abandons the frame with no err and no frame_valid.
- No state advances in non-strobe cycles.
- IDLE:
  - Count consecutive recessive strobes, saturating at IFS_BITS; a dominant strobe clears the count.
  - A dominant strobe with count == IFS_BITS is SOF -> ID, busy=1; otherwise the dominant strobe is ignored.
- ID: shift ID_W bits into the id shadow, MSB first -> DLC.
- DLC:
  - Shift 4 bits MSB first.
  - nbytes = min(dlc, MAX_BYTES); DLC 9..15 receives MAX_BYTES bytes.
  - nbytes == 0 -> EOF; otherwise -> DATA.
- DATA: 8*nbytes bits, byte 0 first, each byte MSB first; unused shadow bytes cleared at SOF -> EOF.
- EOF:
  - EOF_BITS strobes required.
  - Any dominant strobe -> err pulse, err_code=01, busy=0, IDLE with recessive count 0; shadow contents discarded.
  - After the last recessive strobe, the next clk edge: frame_valid=1 for one cycle; rx_id/rx_dlc/rx_data loaded from the shadows; err_code=00; busy=0; IDLE with recessive count = 0. EOF does not count toward IFS.
- Outputs change only on frame_valid or reset. A bit_en in the same cycle as frame_valid is processed by IDLE.
- SOF during an error recovery still requires IFS_BITS recessive strobes first.

Optional Feature:
- Macro: CAN_RX_DESTUFF_EN.
- Defined:
  - Bit destuffing from SOF through the last data bit.
  - After 5 consecutive equal bits (SOF counts), the next strobe is a stuff bit and is discarded.
  - A stuff bit equal to the preceding bits -> err pulse, err_code=10, busy=0, IDLE, recessive count 0.
  - A stuff bit counts as the first bit of the next run.
  - No destuffing in EOF.
- Undefined: every strobe is a data bit; err_code 10 is never produced.

Decomposition:
- Package can_pkg: state encoding (IDLE, ID, DLC, DATA, EOF), err_code constants (ERR_NONE, ERR_FORM, ERR_STUFF), DLC_BYTES_MAX=8.
- Sub-module can_bit_destuffer (run counter plus stuff flag/error), instantiated only under CAN_RX_DESTUFF_EN.

Test Plan:
1. 3 recessive, SOF, ID 0x123, DLC 2, data 0xA5 then 0x3C, 7 recessive (destuff off) -> one frame_valid; rx_id=0x123, rx_dlc=2, rx_data[15:0]=0x3CA5, upper bytes 0, err=0, busy low after the pulse.
2. DLC 0 followed directly by 7 recessive -> frame_valid; rx_data all 0. Then DLC 12 with 8 bytes 0x01..0x08 -> rx_dlc=12, rx_data[63:0]=0x0807060504030201.
3. Dominant on EOF bit 4 -> err=1 with err_code=01, no frame_valid, prior rx_* unchanged. A dominant bit after only 2 recessive bits is ignored; the SOF after 3 recessive bits is accepted.
4. bit_en every 4th cycle vs bit_en every cycle for the frame of test 1 -> identical outputs. A SOF with only 1 recessive bit before it is ignored.
5. rst pulsed during byte 1 of DATA -> all outputs 0 asynchronously, busy=0, no err. A following clean frame with ID 0x7FF, DLC 1, data 0x00 is received correctly.
6. CAN_RX_DESTUFF_EN, ID 0x7C0:
   - Run of five 1s followed by a stuff 0 is removed; rx_id=0x7C0.
   - Same frame with the sixth bit 1 -> err_code=10.
   - Run of 0s: SOF plus four 0s, stuff 1 -> accepted.
